poly_control: RTL and testbench

Control FSM for the 8-bit polynomial datapath. It sequences operand entry (A, B, C, X) from a single `go` button, then issues five ALU micro-operations that compute Y = A·X² + B·X + C (mod 256) into the datapath's result register. It sits directly upstream of the datapath and drives every one of its load, select and opcode inputs; `data_in` goes straight from the switches to the datapath and never passes through this block.

---
 rtl/poly_control_if.sv | 28 ++
 rtl/poly_control.sv | 122 ++++++++++++
 tb/tb_poly_control.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_control_if.sv
// Control bundle between the polynomial sequencer and its datapath.
// master = sequencer (drives loads/selects/status, reads go); slave = datapath/operator side.
interface poly_control_if;
    logic       go;
    logic       ld_a;
    logic       ld_b;
    logic       ld_c;
    logic       ld_x;
    logic       ld_alu_out;
    logic       ld_r;
    logic       alu_op;
    logic [1:0] alu_select_a;
    logic [1:0] alu_select_b;
    logic       busy;
    logic       result_valid;

    modport master (
        input  go,
        output ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r,
        output alu_op, alu_select_a, alu_select_b, busy, result_valid
    );

    modport slave (
        output go,
        input  ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r,
        input  alu_op, alu_select_a, alu_select_b, busy, result_valid
    );
endinterface

// File: rtl/poly_control.sv
// Sequencer for Y = A*X^2 + B*X + C: go-driven operand entry, then 5 compute cycles; result 6 edges after X commit.
// No backpressure: go is level-sampled, ignored during compute; held go parks the FSM in its _WAIT state.
module poly_control (
    input  logic           clk,
    input  logic           resetn,
    poly_control_if.master ctrl
);

    typedef enum logic [3:0] {
        S_LOAD_A      = 4'd0,
        S_LOAD_A_WAIT = 4'd1,
        S_LOAD_B      = 4'd2,
        S_LOAD_B_WAIT = 4'd3,
        S_LOAD_C      = 4'd4,
        S_LOAD_C_WAIT = 4'd5,
        S_LOAD_X      = 4'd6,
        S_LOAD_X_WAIT = 4'd7,
        S_CYCLE_0     = 4'd8,
        S_CYCLE_1     = 4'd9,
        S_CYCLE_2     = 4'd10,
        S_CYCLE_3     = 4'd11,
        S_CYCLE_4     = 4'd12
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_LOAD_A;
        case (state)
            S_LOAD_A:      next_state = ctrl.go ? S_LOAD_A_WAIT : S_LOAD_A;
            S_LOAD_A_WAIT: next_state = ctrl.go ? S_LOAD_A_WAIT : S_LOAD_B;
            S_LOAD_B:      next_state = ctrl.go ? S_LOAD_B_WAIT : S_LOAD_B;
            S_LOAD_B_WAIT: next_state = ctrl.go ? S_LOAD_B_WAIT : S_LOAD_C;
            S_LOAD_C:      next_state = ctrl.go ? S_LOAD_C_WAIT : S_LOAD_C;
            S_LOAD_C_WAIT: next_state = ctrl.go ? S_LOAD_C_WAIT : S_LOAD_X;
            S_LOAD_X:      next_state = ctrl.go ? S_LOAD_X_WAIT : S_LOAD_X;
            S_LOAD_X_WAIT: next_state = ctrl.go ? S_LOAD_X_WAIT : S_CYCLE_0;
            S_CYCLE_0:     next_state = S_CYCLE_1;
            S_CYCLE_1:     next_state = S_CYCLE_2;
            S_CYCLE_2:     next_state = S_CYCLE_3;
            S_CYCLE_3:     next_state = S_CYCLE_4;
            S_CYCLE_4:     next_state = S_LOAD_A;
            default:       next_state = S_LOAD_A;
        endcase
    end

    always_comb begin
        ctrl.ld_a         = 1'b0;
        ctrl.ld_b         = 1'b0;
        ctrl.ld_c         = 1'b0;
        ctrl.ld_x         = 1'b0;
        ctrl.ld_alu_out   = 1'b0;
        ctrl.ld_r         = 1'b0;
        ctrl.alu_op       = 1'b0;
        ctrl.alu_select_a = SEL_A;
        ctrl.alu_select_b = SEL_A;
        ctrl.busy         = 1'b0;
        case (state)
            S_LOAD_A, S_LOAD_A_WAIT: ctrl.ld_a = 1'b1;
            S_LOAD_B, S_LOAD_B_WAIT: ctrl.ld_b = 1'b1;
            S_LOAD_C, S_LOAD_C_WAIT: ctrl.ld_c = 1'b1;
            S_LOAD_X, S_LOAD_X_WAIT: ctrl.ld_x = 1'b1;
            // Two back-to-back A*X multiplies build A*X^2 in place.
            S_CYCLE_0, S_CYCLE_1: begin
                ctrl.ld_a         = 1'b1;
                ctrl.ld_alu_out   = 1'b1;
                ctrl.alu_op       = 1'b1;
                ctrl.alu_select_a = SEL_A;
                ctrl.alu_select_b = SEL_X;
                ctrl.busy         = 1'b1;
            end
            S_CYCLE_2: begin
                ctrl.ld_b         = 1'b1;
                ctrl.ld_alu_out   = 1'b1;
                ctrl.alu_op       = 1'b1;
                ctrl.alu_select_a = SEL_B;
                ctrl.alu_select_b = SEL_X;
                ctrl.busy         = 1'b1;
            end
            S_CYCLE_3: begin
                ctrl.ld_a         = 1'b1;
                ctrl.ld_alu_out   = 1'b1;
                ctrl.alu_select_a = SEL_A;
                ctrl.alu_select_b = SEL_B;
                ctrl.busy         = 1'b1;
            end
            S_CYCLE_4: begin
                ctrl.ld_r         = 1'b1;
                ctrl.alu_select_a = SEL_A;
                ctrl.alu_select_b = SEL_C;
                ctrl.busy         = 1'b1;
            end
            default: ;
        endcase
    end

    // Valid spans from the result write until the next operand entry begins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl.result_valid <= 1'b0;
        end else if (state == S_CYCLE_4) begin
            ctrl.result_valid <= 1'b1;
        end else if (state == S_LOAD_A && ctrl.go) begin
            ctrl.result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_control.sv
// Directed bench for poly_control with a behavioural 8-bit datapath driven by its controls.
// Inputs driven and outputs sampled on the falling edge.
module tb_poly_control;

    logic       clk;
    logic       resetn;
    logic [7:0] data_in;

    poly_control_if bus ();

    poly_control dut (
        .clk    (clk),
        .resetn (resetn),
        .ctrl   (bus)
    );

    int n_tests;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference datapath: registers A, B, C, X, R and a 2-operand ALU.
    logic [7:0] ra, rb, rc, rx, data_result;
    logic [7:0] alu_a, alu_b, alu_out;

    always_comb begin
        alu_a = ra;
        alu_b = ra;
        case (bus.alu_select_a)
            2'd0: alu_a = ra;
            2'd1: alu_a = rb;
            2'd2: alu_a = rc;
            default: alu_a = rx;
        endcase
        case (bus.alu_select_b)
            2'd0: alu_b = ra;
            2'd1: alu_b = rb;
            2'd2: alu_b = rc;
            default: alu_b = rx;
        endcase
        alu_out = bus.alu_op ? 8'(alu_a * alu_b) : 8'(alu_a + alu_b);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ra <= 8'd0; rb <= 8'd0; rc <= 8'd0; rx <= 8'd0; data_result <= 8'd0;
        end else begin
            if (bus.ld_a) ra <= bus.ld_alu_out ? alu_out : data_in;
            if (bus.ld_b) rb <= bus.ld_alu_out ? alu_out : data_in;
            if (bus.ld_c) rc <= data_in;
            if (bus.ld_x) rx <= data_in;
            if (bus.ld_r) data_result <= alu_out;
        end
    end

    // {ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r, alu_op, sel_a, sel_b, busy}
    logic [11:0] ctrl_vec;
    assign ctrl_vec = {bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_x, bus.ld_alu_out, bus.ld_r,
                       bus.alu_op, bus.alu_select_a, bus.alu_select_b, bus.busy};

    logic [11:0] dec_exp [0:12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        resetn   = 1'b0;
        bus.go   = 1'b0;
        data_in  = 8'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Press/release go with v on data_in; returns at the negedge after the commit edge.
    task automatic enter(input logic [7:0] v);
        @(negedge clk);
        data_in = v;
        bus.go  = 1'b1;
        @(negedge clk);
        bus.go  = 1'b0;
        @(negedge clk);
    endtask

    // Enters all four operands then counts busy cycles; ends at the negedge after the result edge.
    task automatic run_calc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] x, output int nbusy);
        enter(a);
        enter(b);
        enter(c);
        enter(x);
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.busy) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        bus.go  = 1'b0;
        data_in = 8'd0;
        #3;
        n_tests++;
        if (ctrl_vec !== 12'h800) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h required %h", ctrl_vec, 12'h800);
        end
        n_tests++;
        if (bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b required 0", bus.result_valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int nb;
        run_calc(8'd2, 8'd3, 8'd4, 8'd5, nb);
        n_tests++;
        if (nb != 5) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d required 5", nb);
        end
        n_tests++;
        if (data_result !== 8'h45) begin
            n_fail++;
            $display("FAIL basic_result: got %h required 45", data_result);
        end
        n_tests++;
        if (bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid: got %b required 1", bus.result_valid);
        end
    endtask

    task automatic test_wrap();
        int nb;
        run_calc(8'd10, 8'd0, 8'd0, 8'd10, nb);
        n_tests++;
        if (data_result !== 8'hE8) begin
            n_fail++;
            $display("FAIL wrap_result: got %h required e8", data_result);
        end
        n_tests++;
        if (nb != 5) begin
            n_fail++;
            $display("FAIL wrap_busy_cycles: got %0d required 5", nb);
        end
    endtask

    task automatic test_hold_go();
        int nb;
        do_reset();
        enter(8'd7);
        data_in = 8'd8;
        bus.go  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_tests++;
            if (ctrl_vec !== 12'h400) begin
                n_fail++;
                $display("FAIL hold_ldb cycle %0d: got %h required %h", k, ctrl_vec, 12'h400);
            end
        end
        bus.go = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ctrl_vec !== 12'h200) begin
            n_fail++;
            $display("FAIL hold_release_to_c: got %h required %h", ctrl_vec, 12'h200);
        end
        data_in = 8'd99;
        @(negedge clk);
        data_in = 8'd50;
        @(negedge clk);
        data_in = 8'd4;
        bus.go  = 1'b1;
        @(negedge clk);
        bus.go  = 1'b0;
        @(negedge clk);
        enter(8'd5);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.busy) break;
            nb++;
            @(negedge clk);
        end
        n_tests++;
        if (data_result !== 8'hDB) begin
            n_fail++;
            $display("FAIL hold_result: got %h required db", data_result);
        end
        n_tests++;
        if (nb != 5) begin
            n_fail++;
            $display("FAIL hold_busy_cycles: got %0d required 5", nb);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        do_reset();
        enter(8'd2);
        enter(8'd3);
        enter(8'd4);
        enter(8'd5);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (ctrl_vec !== 12'h4AF) begin
            n_fail++;
            $display("FAIL mid_cycle2_decode: got %h required %h", ctrl_vec, 12'h4AF);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (ctrl_vec !== 12'h800) begin
            n_fail++;
            $display("FAIL mid_async_reset: got %h required %h", ctrl_vec, 12'h800);
        end
        n_tests++;
        if (bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_valid: got %b required 0", bus.result_valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_calc(8'd1, 8'd1, 8'd1, 8'd1, nb);
        n_tests++;
        if (data_result !== 8'h03 || bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fresh_result: got %h/%b required 03/1", data_result, bus.result_valid);
        end
    endtask

    task automatic test_decode();
        dec_exp = '{12'h800, 12'h800, 12'h400, 12'h400, 12'h200, 12'h200, 12'h100, 12'h100,
                    12'h8A7, 12'h8A7, 12'h4AF, 12'h883, 12'h045};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            n_tests++;
            if (ctrl_vec !== dec_exp[i]) begin
                n_fail++;
                $display("FAIL decode_step %0d: got %h required %h", i, ctrl_vec, dec_exp[i]);
            end
            data_in = 8'd2;
            bus.go  = (i < 8) ? ((i % 2) == 0) : ((i % 2) == 1);
            @(negedge clk);
        end
        n_tests++;
        if (ctrl_vec !== 12'h800 || bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_end: got %h/%b required 800/1", ctrl_vec, bus.result_valid);
        end
        n_tests++;
        if (data_result !== 8'd14) begin
            n_fail++;
            $display("FAIL decode_result: got %0d required 14", data_result);
        end
    endtask

    task automatic test_back_to_back();
        data_in = 8'd9;
        bus.go  = 1'b1;
        n_tests++;
        if (bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_valid_before: got %b required 1", bus.result_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.result_valid !== 1'b0 || data_result !== 8'd14) begin
            n_fail++;
            $display("FAIL b2b_valid_clear: got %b/%0d required 0/14", bus.result_valid, data_result);
        end
        bus.go = 1'b0;
        @(negedge clk);
        enter(8'd1);
        enter(8'd2);
        enter(8'd3);
        repeat (4) @(negedge clk);
        n_tests++;
        if (data_result !== 8'd14 || bus.ld_r !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_old_held: got %0d/ld_r=%b required 14/1", data_result, bus.ld_r);
        end
        @(negedge clk);
        n_tests++;
        if (data_result !== 8'd86 || bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_new_result: got %0d/%b required 86/1", data_result, bus.result_valid);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_hold_go();
        test_reset_mid();
        test_decode();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
